phy_utx_fifo: RTL

Parametrised UART transmitter for the commu_top PHY layer, and the successor to the fixed 8N1 microsecond-tick transmitter. It buffers outgoing words in an internal FIFO behind a valid/ready handshake. It generates its own bit timing from `clk_sys` through an integer divider. Frame format is set by parameters: data width, parity mode and stop-bit count. Frames go out back-to-back with no idle gap while data is queued.

---
 rtl/phy_utx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/phy_utx_fifo.sv
// UART transmitter with an input FIFO: frames of DW data bits, optional parity and
// one or two stop bits, timed by an integer divider of clk_sys, sent back-to-back.
module phy_utx_fifo #(
   parameter int DW         = 8,
   parameter int CLK_DIV    = 100,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk_sys,
   input  logic                          rst,
   input  logic [DW-1:0]                 tx_data,
   input  logic                          tx_vld,
   output logic                          tx_rdy,
   input  logic                          tx_en,
   output logic                          uart_tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = 4;

   if (DW < 5 || DW > 9) begin : g_bad_dw
      $error("phy_utx_fifo: DW must be in 5..9");
   end
   if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_div
      $error("phy_utx_fifo: CLK_DIV must be in 2..65535");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("phy_utx_fifo: FIFO_DEPTH must be a power of two in 2..256");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("phy_utx_fifo: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("phy_utx_fifo: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic [DW-1:0] head;
   logic          push, pop, launch, bit_end, frame_done;

   state_t        state_q;
   logic [CW-1:0] baud_q;
   logic [BW-1:0] bit_q;
   logic [DW-1:0] shift_q;
   logic          par_q, tx_q, busy_q;

   assign tx_rdy     = (level_q != LW'(FIFO_DEPTH));
   assign push       = tx_vld & tx_rdy;
   assign head       = mem_q[rd_ptr_q];
   assign bit_end    = (state_q != S_IDLE) && (baud_q == CW'(CLK_DIV - 1));
   assign frame_done = (state_q == S_STOP) && bit_end && (bit_q == BW'(STOP_BITS - 1));
   // A frame launches from IDLE or straight out of the last stop bit, so no idle bit appears.
   assign launch     = (level_q != '0) && tx_en && ((state_q == S_IDLE) || frame_done);
   assign pop        = launch;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      level_d = level_q;
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // NOTE: storage is deliberately not reset; clearing the pointers makes stale entries unreachable.
   always_ff @(posedge clk_sys) begin
      if (push) mem_q[wr_ptr_q] <= tx_data;
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else if (launch) begin
         state_q <= S_START;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= head;
         par_q   <= (PARITY == 1) ? ~(^head) : ^head;
         tx_q    <= 1'b0;
         busy_q  <= 1'b1;
      end else if (state_q != S_IDLE) begin
         baud_q <= bit_end ? '0 : baud_q + CW'(1);
         if (bit_end) begin
            unique case (state_q)
               S_START: begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
               end
               S_DATA: begin
                  if (bit_q == BW'(DW - 1)) begin
                     bit_q <= '0;
                     if (PARITY != 0) begin
                        state_q <= S_PAR;
                        tx_q    <= par_q;
                     end else begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + BW'(1);
                     shift_q <= shift_q >> 1;
                     tx_q    <= shift_q[1];
                  end
               end
               S_PAR: begin
                  state_q <= S_STOP;
                  bit_q   <= '0;
                  tx_q    <= 1'b1;
               end
               S_STOP: begin
                  if (frame_done) begin
                     state_q <= S_IDLE;
                     bit_q   <= '0;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign uart_tx    = tx_q;
   assign tx_busy    = busy_q;
   assign fifo_level = level_q;

endmodule
